// File: rtl/radio_seq_ctrl.sv
// Radio session sequencer: warm-up, RX window, cool-down, with abort and isolation handling.
// Optional RADIO_SEQ_ABORT_CNT_EN adds a saturating abort/isolation-exit counter output.
module radio_seq_ctrl #(
    parameter int CNT_W        = 16,
    parameter int WARMUP_CYC   = 8,
    parameter int COOLDOWN_CYC = 4
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             isolateM1M2,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_rx_len,
    input  logic             abort,
    output logic             radioEnableSynced,
    output logic             radioRxEnSynced,
    output logic             busy,
    output logic             done,
`ifdef RADIO_SEQ_ABORT_CNT_EN
    output logic             done_aborted,
    output logic [7:0]       abort_cnt
`else
    output logic             done_aborted
`endif
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WARMUP   = 2'd1;
    localparam logic [1:0] RX       = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN_CYC - 1);

    logic [1:0]       state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;
    logic [CNT_W-1:0] len_q, nlen;
    logic             aborted, naborted;
    logic             ndone;
`ifdef RADIO_SEQ_ABORT_CNT_EN
    logic             abort_evt;
`endif

    assign req_ready = (state == IDLE) & ~isolateM1M2;

    // Priority: isolation > abort > counter expiry > request accept.
    always_comb begin
        nstate   = state;
        ncnt     = cnt;
        nlen     = len_q;
        naborted = aborted;
        ndone    = 1'b0;
`ifdef RADIO_SEQ_ABORT_CNT_EN
        abort_evt = 1'b0;
`endif
        if (isolateM1M2) begin
            nstate   = IDLE;
            ncnt     = '0;
            nlen     = '0;
            naborted = 1'b0;
`ifdef RADIO_SEQ_ABORT_CNT_EN
            abort_evt = (state != IDLE);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        nstate   = WARMUP;
                        ncnt     = WARM_INIT;
                        nlen     = req_rx_len;
                        naborted = 1'b0;
                    end
                end
                WARMUP, RX: begin
                    if (abort) begin
                        nstate   = COOLDOWN;
                        ncnt     = COOL_INIT;
                        naborted = 1'b1;
`ifdef RADIO_SEQ_ABORT_CNT_EN
                        abort_evt = 1'b1;
`endif
                    end else if (cnt == '0) begin
                        if (state == WARMUP && len_q != '0) begin
                            nstate = RX;
                            ncnt   = len_q - CNT_W'(1);
                        end else begin
                            nstate = COOLDOWN;
                            ncnt   = COOL_INIT;
                        end
                    end else begin
                        ncnt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        nstate = IDLE;
                        ndone  = 1'b1;
                    end else begin
                        ncnt = cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the radio controls come straight from flops.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state             <= IDLE;
            cnt               <= '0;
            len_q             <= '0;
            aborted           <= 1'b0;
            radioEnableSynced <= 1'b0;
            radioRxEnSynced   <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            done_aborted      <= 1'b0;
        end else begin
            state             <= nstate;
            cnt               <= ncnt;
            len_q             <= nlen;
            aborted           <= naborted;
            radioEnableSynced <= (nstate != IDLE);
            radioRxEnSynced   <= (nstate == RX);
            busy              <= (nstate != IDLE);
            done              <= ndone;
            done_aborted      <= ndone & aborted;
        end
    end

`ifdef RADIO_SEQ_ABORT_CNT_EN
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            abort_cnt <= '0;
        end else if (abort_evt && abort_cnt != 8'hFF) begin
            abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_radio_seq_ctrl.sv
// Self-checking bench for radio_seq_ctrl: directed scenarios plus random traffic against a
// cycle-offset model of a session (enable/RX windows computed from accept time and length).
module tb_radio_seq_ctrl;

    localparam int W = 8;
    localparam int C = 4;

    logic        ck;
    logic        arst;
    logic        isolateM1M2;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_rx_len;
    logic        abort;
    logic        radioEnableSynced;
    logic        radioRxEnSynced;
    logic        busy;
    logic        done;
    logic        done_aborted;
`ifdef RADIO_SEQ_ABORT_CNT_EN
    logic [7:0]  abort_cnt;
`endif

    radio_seq_ctrl #(
        .CNT_W(16),
        .WARMUP_CYC(W),
        .COOLDOWN_CYC(C)
    ) dut (
        .ck(ck),
        .arst(arst),
        .isolateM1M2(isolateM1M2),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rx_len(req_rx_len),
        .abort(abort),
        .radioEnableSynced(radioEnableSynced),
        .radioRxEnSynced(radioRxEnSynced),
        .busy(busy),
        .done(done),
`ifdef RADIO_SEQ_ABORT_CNT_EN
        .done_aborted(done_aborted),
        .abort_cnt(abort_cnt)
`else
        .done_aborted(done_aborted)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;

    // Session model: k = cycles since accept; enable for k in 1..en_end, RX for k in W+1..rx_end.
    bit m_active;
    int m_k, m_rx_end, m_en_end;
    bit m_ab;
    bit m_done, m_done_ab;
    int m_abort_cnt;

    function automatic void model_reset();
        m_active = 0; m_k = 0; m_rx_end = 0; m_en_end = 0; m_ab = 0;
        m_done = 0; m_done_ab = 0; m_abort_cnt = 0;
    endfunction

    function automatic void model_edge(bit iso, bit rv, int len, bit ab);
        m_done = 0;
        m_done_ab = 0;
        if (iso) begin
            if (m_active && m_abort_cnt < 255) m_abort_cnt++;
            m_active = 0;
        end else if (m_active) begin
            if (ab && m_k <= m_rx_end) begin
                m_rx_end = m_k;
                m_en_end = m_k + C;
                m_ab = 1;
                if (m_abort_cnt < 255) m_abort_cnt++;
                m_k++;
            end else if (m_k == m_en_end) begin
                m_active = 0;
                m_done = 1;
                m_done_ab = m_ab;
            end else begin
                m_k++;
            end
        end else if (rv) begin
            m_active = 1;
            m_k = 1;
            m_rx_end = W + len;
            m_en_end = W + len + C;
            m_ab = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("radioEnableSynced", 32'(radioEnableSynced), 32'(m_active));
        check("radioRxEnSynced", 32'(radioRxEnSynced), 32'(m_active && m_k > W && m_k <= m_rx_end));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("done_aborted", 32'(done_aborted), 32'(m_done_ab));
        check("req_ready", 32'(req_ready), 32'(!m_active && !isolateM1M2));
`ifdef RADIO_SEQ_ABORT_CNT_EN
        check("abort_cnt", 32'(abort_cnt), 32'(m_abort_cnt));
`endif
    endtask

    task automatic step(input bit iso, input bit rv, input int len, input bit ab);
        isolateM1M2 = iso;
        req_valid   = rv;
        req_rx_len  = 16'(len);
        abort       = ab;
        @(posedge ck);
        model_edge(iso, rv, len, ab);
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        arst = 1'b1;
        isolateM1M2 = 1'b0;
        req_valid = 1'b0;
        req_rx_len = '0;
        abort = 1'b0;
        model_reset();
        #12;
        arst = 1'b0;
        #1;
        compare_all();

        // Basic session, L=5: enable 1..17, RX 9..13, done at 18.
        step(0, 1, 5, 0);
        idle_steps(20);

        // L=0 skips RX.
        step(0, 1, 0, 0);
        idle_steps(15);

        // L=100 with abort in cycle 20.
        step(0, 1, 100, 0);
        idle_steps(19);
        step(0, 0, 0, 1);
        idle_steps(8);

        // Abort in warm-up, then abort in cool-down (ignored).
        step(0, 1, 10, 0);
        idle_steps(2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle_steps(6);

        // Isolation at cycle 10 of a len=50 session, held for three cycles.
        step(0, 1, 50, 0);
        idle_steps(9);
        step(1, 1, 7, 0);
        step(1, 1, 7, 0);
        step(1, 1, 7, 0);
        step(0, 0, 0, 0);
        idle_steps(3);

        // Back-to-back sessions with req_valid held high.
        for (int i = 0; i < 36; i++) step(0, 1, 3, 0);
        idle_steps(20);

        // Asynchronous reset mid-RX, then a fresh session.
        step(0, 1, 50, 0);
        idle_steps(12);
        #2;
        arst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2;
        arst = 1'b0;
        step(0, 1, 5, 0);
        idle_steps(20);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)),
                 ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
